// File: rtl/pic_ctrl.sv
// ---------------------------------------------------------------------------
// pic_ctrl -- small programmable interrupt controller
//
// Collects up to NUM_IRQ interrupt requests (edge or level per channel),
// arbitrates them with fixed or rotating priority against the in-service
// set, raises int_out to the CPU and returns a vector on acknowledge.
//
// Ports
//   clk, rst       : clock, synchronous active-high reset
//   cs, wr, rd     : register chip select, write strobe, read enable
//   addr, din      : register select, write data
//   dout           : combinational read data (0 unless cs & rd)
//   irq            : interrupt request lines
//   int_out        : registered interrupt request to the CPU
//   inta           : one-cycle acknowledge pulse from the CPU
//   vector         : acknowledged vector (registered)
//   vector_valid   : one-cycle qualifier for vector
//
// Register map: 0 IMR, 1 IRR / command, 2 ISR / mode, 3 ELCR.
// ---------------------------------------------------------------------------
module pic_ctrl #(
    parameter int         NUM_IRQ  = 8,
    parameter logic [7:0] VEC_BASE = 8'h08
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cs,
    input  logic               wr,
    input  logic               rd,
    input  logic [1:0]         addr,
    input  logic [7:0]         din,
    output logic [7:0]         dout,
    input  logic [NUM_IRQ-1:0] irq,
    output logic               int_out,
    input  logic               inta,
    output logic [7:0]         vector,
    output logic               vector_valid
);

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    localparam logic [3:0] N_L   = 4'(NUM_IRQ);
    localparam logic [7:0] VMASK = 8'((16'd1 << NUM_IRQ) - 16'd1);

    // Wrap a channel sum back into 0..NUM_IRQ-1.
    function automatic logic [3:0] mod_f(input logic [3:0] s);
        return (s >= N_L) ? (s - N_L) : s;
    endfunction

    // Priority rank of a channel; 0 is the highest priority.
    function automatic logic [3:0] rank_f(input logic [2:0] ch, input logic rot,
                                          input logic [2:0] hi);
        logic [3:0] r;
        if (!rot) begin
            r = {1'b0, ch};
        end else if (ch >= hi) begin
            r = {1'b0, ch} - {1'b0, hi};
        end else begin
            r = {1'b0, ch} + N_L - {1'b0, hi};
        end
        return r;
    endfunction

    // Highest-priority set bit of v as {found, index}. Scans from lowest to
    // highest priority so the last hit is the winner.
    function automatic logic [3:0] top_f(input logic [7:0] v, input logic rot,
                                         input logic [2:0] hi);
        logic [3:0] res;
        logic [3:0] ch;
        res = 4'd0;
        for (int r = NUM_IRQ - 1; r >= 0; r--) begin
            ch = rot ? mod_f({1'b0, hi} + 4'(r)) : 4'(r);
            if (v[ch[2:0]]) begin
                res = {1'b1, ch[2:0]};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // True when some request strictly outranks every in-service channel.
    function automatic logic pending_f(input logic [7:0] req, input logic [7:0] isr,
                                       input logic rot, input logic [2:0] hi);
        logic [3:0] t;
        logic [3:0] s;
        t = top_f(req, rot, hi);
        s = top_f(isr, rot, hi);
        return t[3] && (!s[3] || (rank_f(t[2:0], rot, hi) < rank_f(s[2:0], rot, hi)));
    endfunction

    // The pointer holds the lowest-priority channel; highest is the next one up.
    function automatic logic [2:0] hi_f(input logic [2:0] low);
        return ({1'b0, low} == (N_L - 4'd1)) ? 3'd0 : (low + 3'd1);
    endfunction

    state_t     state_q, state_d;
    logic [7:0] imr_q, imr_d;
    logic [7:0] irr_q, irr_d;
    logic [7:0] isr_q, isr_d;
    logic [7:0] elcr_q, elcr_d;
    logic       rotate_q, rotate_d;
    logic       aeoi_q, aeoi_d;
    logic [2:0] low_q, low_d;
    logic [7:0] irq_prev_q, irq_prev_d;
    logic       int_out_q, int_out_d;
    logic [7:0] vector_q, vector_d;
    logic       vector_valid_q, vector_valid_d;

    logic [7:0] irq_ext_s;
    logic [2:0] hi_s;
    logic       wr_en_s;
    logic [3:0] isr_top_s;
    logic [7:0] isr_eoi_s;
    logic [2:0] low_eoi_s;
    logic [7:0] req_s;
    logic [3:0] req_top_s;
    logic       win_s;
    logic       ack_s;
    logic [7:0] win_oh_s;

    // Zero-extend the request lines to the 8-bit internal register width.
    always_comb begin
        irq_ext_s = 8'h00;
        irq_ext_s[NUM_IRQ-1:0] = irq;
    end

    // Command decode, arbitration, acknowledge FSM and next-state values.
    always_comb begin
        hi_s      = hi_f(low_q);
        wr_en_s   = cs && wr;
        imr_d     = imr_q;
        elcr_d    = elcr_q;
        rotate_d  = rotate_q;
        aeoi_d    = aeoi_q;
        state_d   = state_q;
        vector_d  = 8'h00;
        vector_valid_d = 1'b0;
        irq_prev_d = irq_ext_s;

        // EOI is resolved first so a same-cycle acknowledge sees its result.
        isr_top_s = top_f(isr_q, rotate_q, hi_s);
        isr_eoi_s = isr_q;
        low_eoi_s = low_q;
        if (wr_en_s && (addr == 2'd1)) begin
            case (din[7:5])
                3'b001: begin
                    if (isr_top_s[3]) begin
                        isr_eoi_s[isr_top_s[2:0]] = 1'b0;
                        low_eoi_s = isr_top_s[2:0];
                    end else begin
                        isr_eoi_s = isr_q;
                    end
                end
                3'b011: begin
                    if (({1'b0, din[2:0]} < N_L) && isr_q[din[2:0]]) begin
                        isr_eoi_s[din[2:0]] = 1'b0;
                        low_eoi_s = din[2:0];
                    end else begin
                        isr_eoi_s = isr_q;
                    end
                end
                default: isr_eoi_s = isr_q;
            endcase
        end else begin
            isr_eoi_s = isr_q;
        end

        // Register writes other than commands; IMR updates after arbitration.
        if (wr_en_s) begin
            case (addr)
                2'd0:    imr_d = din & VMASK;
                2'd2:    begin rotate_d = din[0]; aeoi_d = din[1]; end
                2'd3:    elcr_d = din & VMASK;
                default: imr_d = imr_q;
            endcase
        end else begin
            imr_d = imr_q;
        end

        // Arbitration uses the pre-write IMR and the post-EOI ISR.
        req_s     = irr_q & ~imr_q & VMASK;
        req_top_s = top_f(req_s, rotate_q, hi_s);
        win_s     = pending_f(req_s, isr_eoi_s, rotate_q, hi_s);
        ack_s     = (state_q == IDLE) && inta;
        win_oh_s  = (ack_s && win_s) ? (8'h01 << req_top_s[2:0]) : 8'h00;

        case (state_q)
            IDLE: begin
                if (inta) begin
                    state_d = ACK;
                    vector_valid_d = 1'b1;
                    if (win_s) begin
                        vector_d = VEC_BASE + {5'd0, req_top_s[2:0]};
                    end else begin
                        vector_d = VEC_BASE + 8'(NUM_IRQ - 1);
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Auto-EOI skips the ISR and rotates on the winner directly.
        if (aeoi_q) begin
            isr_d = isr_eoi_s;
            low_d = (ack_s && win_s) ? req_top_s[2:0] : low_eoi_s;
        end else begin
            isr_d = isr_eoi_s | win_oh_s;
            low_d = low_eoi_s;
        end

        // Edge set is applied after the acknowledge clear; level follows irq.
        irr_d = ((irr_q & ~win_oh_s & ~elcr_q)
                | (irq_ext_s & ~irq_prev_q & ~elcr_q)
                | (irq_ext_s & elcr_q)) & VMASK;

        // int_out reflects the state being loaded this edge.
        int_out_d = pending_f(irr_d & ~imr_d, isr_d, rotate_d, hi_f(low_d));
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            imr_q          <= 8'h00;
            irr_q          <= 8'h00;
            isr_q          <= 8'h00;
            elcr_q         <= 8'h00;
            rotate_q       <= 1'b0;
            aeoi_q         <= 1'b0;
            low_q          <= 3'(NUM_IRQ - 1);
            irq_prev_q     <= irq_ext_s;
            int_out_q      <= 1'b0;
            vector_q       <= 8'h00;
            vector_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            imr_q          <= imr_d;
            irr_q          <= irr_d;
            isr_q          <= isr_d;
            elcr_q         <= elcr_d;
            rotate_q       <= rotate_d;
            aeoi_q         <= aeoi_d;
            low_q          <= low_d;
            irq_prev_q     <= irq_prev_d;
            int_out_q      <= int_out_d;
            vector_q       <= vector_d;
            vector_valid_q <= vector_valid_d;
        end
    end

    // Combinational register readback.
    always_comb begin
        dout = 8'h00;
        if (cs && rd) begin
            case (addr)
                2'd0:    dout = imr_q;
                2'd1:    dout = irr_q;
                2'd2:    dout = isr_q;
                2'd3:    dout = elcr_q;
                default: dout = 8'h00;
            endcase
        end else begin
            dout = 8'h00;
        end
    end

    assign int_out      = int_out_q;
    assign vector       = vector_q;
    assign vector_valid = vector_valid_q;

endmodule

// File: doc/pic_ctrl.md
PIC_CTRL -- requirements
Module: pic_ctrl

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 8, number of interrupt channels, legal range 2..8.
REQ-002 SHALL have parameter VEC_BASE, default 8'h08, vector for channel 0 (vector = VEC_BASE + channel index).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port cs, input, 1 bit: register chip select.
REQ-006 SHALL have port wr, input, 1 bit: write strobe, qualified by cs; one write per cycle high.
REQ-007 SHALL have port rd, input, 1 bit: read enable, qualified by cs.
REQ-008 SHALL have port addr, input, 2 bits: register select.
REQ-009 SHALL have port din, input, 8 bits: write data.
REQ-010 SHALL have port dout, output, 8 bits: read data, combinational from addr; 8'h00 when cs=0 or rd=0.
REQ-011 SHALL have port irq, input, NUM_IRQ bits: interrupt request lines.
REQ-012 SHALL have port int_out, output, 1 bit: interrupt request to CPU.
REQ-013 SHALL have port inta, input, 1 bit: one-cycle acknowledge pulse from CPU.
REQ-014 SHALL have port vector, output, 8 bits: acknowledged vector.
REQ-015 SHALL have port vector_valid, output, 1 bit: one-cycle qualifier for vector.

Function
REQ-016 SHALL use this register map:
- addr0: IMR, read/write.
- addr1: read IRR; write = command.
- addr2: read ISR; write = mode.
- addr3: ELCR, read/write; per channel 1 = level, 0 = edge.
- Bits at or above NUM_IRQ read 0 and ignore writes.
REQ-017 SHALL use mode register bits: bit0 = rotating priority, bit1 = auto-EOI; other bits are ignored; readback of mode is not required.
REQ-018 SHALL latch the IRR bit one cycle after irq is sampled 0 then 1 (edge channel).
REQ-019 SHALL set the IRR bit on a level channel each cycle irq is high, and clear it the cycle after irq is low while not yet acknowledged.
REQ-020 SHALL ignore IMR for IRR capture; IMR only gates arbitration.
REQ-021 SHALL use fixed priority when rotate=0: channel 0 highest.
REQ-022 SHALL use rotating priority when rotate=1: the channel last cleared by EOI becomes lowest priority, and the next channel up becomes highest.
REQ-023 SHALL drive int_out as a register, high when some unmasked IRR bit has strictly higher priority than every set ISR bit.
REQ-024 SHALL implement the acknowledge state machine as follows:
- States IDLE, ACK.
- inta in IDLE selects the winner, sets its ISR bit, clears its IRR bit, and enters ACK.
- In ACK, vector = VEC_BASE + winner and vector_valid = 1; return to IDLE next cycle.
- inta in ACK is ignored.
REQ-025 SHALL handle a spurious acknowledge (no winner at inta): vector = VEC_BASE + NUM_IRQ - 1, vector_valid = 1, ISR and IRR unchanged.
REQ-026 SHALL, in auto-EOI mode, not set the ISR bit on acknowledge, and treat the winner as the EOI'd channel for rotation.
REQ-027 SHALL decode command writes (addr1) as follows:
- din[7:5] = 001: non-specific EOI, clears the highest-priority set ISR bit.
- din[7:5] = 011: specific EOI, clears ISR[din[2:0]].
- All other codes are ignored.
- EOI with ISR empty: no effect.
REQ-028 SHALL resolve simultaneous events as follows:
- irq edge in the same cycle as inta on that channel: the edge sets IRR again after the clear.
- IMR write in the same cycle as inta: arbitration uses the pre-write IMR.
- EOI in the same cycle as inta: EOI is applied first, then the ISR set.
REQ-029 SHALL make a specific EOI with din[2:0] >= NUM_IRQ a no-op.
REQ-030 SHALL compute vector as VEC_BASE + index modulo 256 (wrap-around).

Reset
REQ-031 SHALL, while rst = 1, clear IRR, ISR, IMR, ELCR and the mode register, and set the priority pointer to channel 0 highest.
REQ-032 SHALL, while rst = 1, drive int_out = 0, vector = 8'h00, vector_valid = 0, and force the FSM to IDLE, including when rst is asserted mid-acknowledge.
REQ-033 SHALL record no irq edge in the first cycle after rst deasserts for a line that was already high during reset.

Verification
REQ-034 SHALL cover single interrupt: reset; pulse irq[7] -> int_out = 1; inta -> vector = 8'h0F with vector_valid, ISR = 8'h80, int_out = 0; non-specific EOI -> ISR = 8'h00.
REQ-035 SHALL cover double interrupt: irq[5] then irq[4] -> first inta gives 8'h0C, IRR = 8'h20; EOI; second inta gives 8'h0D.
REQ-036 SHALL cover masking: IMR = 8'h20; pulse irq[5] and irq[4] -> inta gives 8'h0C; after EOI int_out stays 0 and IRR = 8'h20; IMR = 0 -> int_out = 1.
REQ-037 SHALL cover rotation: rotate = 1; service irq[0] and EOI; raise irq[0] and irq[1] -> inta gives 8'h09.
REQ-038 SHALL cover level mode with spurious acknowledge: ELCR[3] = 1; irq[3] high then low before inta -> inta gives 8'h0F, ISR unchanged.
REQ-039 SHALL cover reset mid-ACK: rst asserted in the ACK cycle -> vector_valid = 0 and all registers read 8'h00.
